// File: rtl/ppu_mux_pkg.sv
// Shared types and helpers for the N:1 select-and-skid stage.
// State encoding is fixed so it can be matched in debug dumps.
package ppu_mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mux_nx1_comb.sv
// Purpose: N-way WIDTH-bit selector; out-of-range select yields zero and raises oor.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state.
module mux_nx1_comb #(
    parameter int WIDTH = 32,
    parameter int N     = 2,
    parameter int SELW  = 1
) (
    input  logic [N*WIDTH-1:0] din,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   dout,
    output logic               oor
);

    always_comb begin
        dout = '0;
        oor  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                dout = din[k*WIDTH +: WIDTH];
                oor  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_skid.sv
// Purpose: registered N:1 operand select with a 2-entry skid; MUX_SEL_ERR_EN adds a per-word out-of-range flag.
// Latency: one cycle from accept to out_valid when the buffer is empty or popping.
// Backpressure: in_ready drops only when both entries are held; decoded from state, no path from out_ready.
module mux_nx1_skid
    import ppu_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 2,
    localparam int SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] din,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready
`ifdef MUX_SEL_ERR_EN
    ,
    output logic               sel_err
`endif
);

`ifdef MUX_SEL_ERR_EN
    // Each entry carries its error flag in the top bit so it moves with the data.
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    state_t          state_q, state_d;
    logic [EW-1:0]   head_q, head_d;
    logic [EW-1:0]   skid_q, skid_d;
    logic [WIDTH-1:0] mux_dat;
    logic            sel_oor;
    logic [EW-1:0]   sel_word;
    logic            accept;
    logic            pop;

    mux_nx1_comb #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) u_sel (
        .din  (din),
        .sel  (sel),
        .dout (mux_dat),
        .oor  (sel_oor)
    );

`ifdef MUX_SEL_ERR_EN
    assign sel_word = {sel_oor, mux_dat};
    assign sel_err  = out_valid & head_q[WIDTH];
`else
    assign sel_word = mux_dat;
`endif

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q[WIDTH-1:0];
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            head_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        head_d  = sel_word;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d = sel_word;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = sel_word;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        head_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    head_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    // The selector must never leak a stale operand on an out-of-range index.
    assert property (@(posedge clk) disable iff (!rst_n) sel_oor |-> (mux_dat == '0));

endmodule

// File: tb/tb_mux_nx1_skid.sv
// Bench for mux_nx1_skid: an N=4 instance and an N=3 instance checked against queue models.
module tb_mux_nx1_skid;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [127:0] a_din;
    logic [1:0]   a_sel;
    logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [31:0]  a_out_data;
    logic [95:0]  b_din;
    logic [1:0]   b_sel;
    logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [31:0]  b_out_data;
`ifdef MUX_SEL_ERR_EN
    logic         a_sel_err, b_sel_err;
`endif

    mux_nx1_skid #(.WIDTH(32), .N(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(a_din), .sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready)
`ifdef MUX_SEL_ERR_EN
        , .sel_err(a_sel_err)
`endif
    );

    mux_nx1_skid #(.WIDTH(32), .N(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(b_din), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef MUX_SEL_ERR_EN
        , .sel_err(b_sel_err)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Models: a bounded FIFO of capacity two; b entries are {err, data}.
    logic [31:0] a_q[$];
    logic [32:0] b_q[$];

    function automatic logic [31:0] pick(input logic [127:0] d, input int s, input int n);
        if (s >= n) return 32'h0;
        return d[s*32 +: 32];
    endfunction

    task automatic step();
        bit acc, pp;
        @(posedge clk);
        if (a_flush) a_q.delete();
        else begin
            acc = a_in_valid && (a_q.size() < 2);
            pp  = (a_q.size() > 0) && a_out_ready;
            if (pp) a_q.delete(0);
            if (acc) a_q.push_back(pick(a_din, int'(a_sel), 4));
        end
        if (b_flush) b_q.delete();
        else begin
            acc = b_in_valid && (b_q.size() < 2);
            pp  = (b_q.size() > 0) && b_out_ready;
            if (pp) b_q.delete(0);
            if (acc) b_q.push_back({(int'(b_sel) >= 3), pick({32'h0, b_din}, int'(b_sel), 3)});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_a_valid got=%b exp=0", a_out_valid); else n_pass++;
        n_checks++; if (a_out_data !== 32'h0) $display("FAIL reset_a_data got=%h exp=0", a_out_data); else n_pass++;
        n_checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_a_ready got=%b exp=1", a_in_ready); else n_pass++;
        n_checks++; if (b_out_valid !== 1'b0) $display("FAIL reset_b_valid got=%b exp=0", b_out_valid); else n_pass++;
`ifdef MUX_SEL_ERR_EN
        n_checks++; if (b_sel_err !== 1'b0) $display("FAIL reset_b_err got=%b exp=0", b_sel_err); else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        a_q.delete();
        b_q.delete();
        step();
        n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) $display("FAIL reset_release got=%b%b exp=01", a_out_valid, a_in_ready); else n_pass++;
    endtask

    task automatic test_streaming();
        logic [31:0] exp_s[4] = '{32'hAAAA0000, 32'hBBBB0001, 32'hCCCC0002, 32'hDDDD0003};
        a_din = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_sel = 2'(k);
            step();
            n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp_s[k]) $display("FAIL stream_data k=%0d got=%b/%h exp=1/%h", k, a_out_valid, a_out_data, exp_s[k]); else n_pass++;
            n_checks++; if (a_in_ready !== 1'b1) $display("FAIL stream_ready k=%0d got=%b exp=1", k, a_in_ready); else n_pass++;
        end
        a_in_valid = 1'b0;
        step();
        n_checks++; if (a_out_valid !== 1'b0) $display("FAIL stream_drain got=%b exp=0", a_out_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_sel = 2'd2; step();
        n_checks++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_one got=%b exp=1", a_in_ready); else n_pass++;
        a_sel = 2'd1; step();
        n_checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_ready_full got=%b exp=0", a_in_ready); else n_pass++;
        a_sel = 2'd3; step(); step();
        n_checks++; if (a_out_data !== 32'hCCCC0002 || a_out_valid !== 1'b1) $display("FAIL bp_hold got=%b/%h exp=1/cccc0002", a_out_valid, a_out_data); else n_pass++;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        step();
        n_checks++; if (a_out_data !== 32'hBBBB0001 || a_out_valid !== 1'b1) $display("FAIL bp_second got=%b/%h exp=1/bbbb0001", a_out_valid, a_out_data); else n_pass++;
        step();
        n_checks++; if (a_out_valid !== 1'b0) $display("FAIL bp_nodup got=%b exp=0", a_out_valid); else n_pass++;
    endtask

    task automatic test_accept_pop();
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_sel = 2'd0;
        step();
        a_out_ready = 1'b1; a_sel = 2'd3;
        step();
        n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hDDDD0003) $display("FAIL accpop_data got=%b/%h exp=1/dddd0003", a_out_valid, a_out_data); else n_pass++;
        n_checks++; if (a_in_ready !== 1'b1) $display("FAIL accpop_ready got=%b exp=1", a_in_ready); else n_pass++;
        a_in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        a_sel = 2'd1; step();
        a_sel = 2'd2; step();
        a_out_ready = 1'b1; a_sel = 2'd0; a_flush = 1'b1;
        step();
        a_flush = 1'b0; a_in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 32'h0) $display("FAIL flush_state got=%b%b/%h exp=01/0", a_out_valid, a_in_ready, a_out_data); else n_pass++;
        step();
        n_checks++; if (a_out_valid !== 1'b0) $display("FAIL flush_drop got=%b exp=0", a_out_valid); else n_pass++;
    endtask

    task automatic test_out_of_range();
        b_din = {32'h33330002, 32'h22220001, 32'h11110000};
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_sel = 2'd3;
        step();
        n_checks++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h0) $display("FAIL oor_data got=%b/%h exp=1/0", b_out_valid, b_out_data); else n_pass++;
`ifdef MUX_SEL_ERR_EN
        n_checks++; if (b_sel_err !== 1'b1) $display("FAIL oor_err got=%b exp=1", b_sel_err); else n_pass++;
`endif
        b_sel = 2'd0;
        step();
        n_checks++; if (b_out_data !== 32'h11110000) $display("FAIL oor_next got=%h exp=11110000", b_out_data); else n_pass++;
`ifdef MUX_SEL_ERR_EN
        n_checks++; if (b_sel_err !== 1'b0) $display("FAIL oor_err_clear got=%b exp=0", b_sel_err); else n_pass++;
`endif
        b_in_valid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        a_sel = 2'd1; step();
        a_sel = 2'd3; step();
        a_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        a_q.delete();
        b_q.delete();
        #1;
        n_checks++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h0) $display("FAIL areset_out got=%b/%h exp=0/0", a_out_valid, a_out_data); else n_pass++;
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) $display("FAIL areset_release got=%b%b exp=10", a_in_ready, a_out_valid); else n_pass++;
    endtask

    task automatic test_random();
        bit exp_v;
        for (int c = 0; c < 600; c++) begin
            a_din = {$urandom, $urandom, $urandom, $urandom};
            a_sel = 2'($urandom_range(0, 3));
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 19) == 0);
            b_din = {$urandom, $urandom, $urandom};
            b_sel = 2'($urandom_range(0, 3));
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 1) != 0);
            b_flush     = ($urandom_range(0, 19) == 0);
            step();
            exp_v = (a_q.size() > 0);
            n_checks++; if (a_out_valid !== exp_v || a_in_ready !== (a_q.size() < 2)) $display("FAIL rnd_a_hs c=%0d got=%b%b exp=%b%b", c, a_out_valid, a_in_ready, exp_v, a_q.size() < 2); else n_pass++;
            if (exp_v) begin
                n_checks++; if (a_out_data !== a_q[0]) $display("FAIL rnd_a_data c=%0d got=%h exp=%h", c, a_out_data, a_q[0]); else n_pass++;
            end
            exp_v = (b_q.size() > 0);
            n_checks++; if (b_out_valid !== exp_v || b_in_ready !== (b_q.size() < 2)) $display("FAIL rnd_b_hs c=%0d got=%b%b exp=%b%b", c, b_out_valid, b_in_ready, exp_v, b_q.size() < 2); else n_pass++;
            if (exp_v) begin
                n_checks++; if (b_out_data !== b_q[0][31:0]) $display("FAIL rnd_b_data c=%0d got=%h exp=%h", c, b_out_data, b_q[0][31:0]); else n_pass++;
            end
`ifdef MUX_SEL_ERR_EN
            n_checks++; if (b_sel_err !== (exp_v && b_q[0][32])) $display("FAIL rnd_b_err c=%0d got=%b exp=%b", c, b_sel_err, exp_v && b_q[0][32]); else n_pass++;
            n_checks++; if (a_sel_err !== 1'b0) $display("FAIL rnd_a_err c=%0d got=%b exp=0", c, a_sel_err); else n_pass++;
`endif
        end
        a_flush = 1'b0; b_flush = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_din = '0; a_sel = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_din = '0; b_sel = '0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_accept_pop();
        test_flush();
        test_out_of_range();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_nx1_skid.md
Name: mux_nx1_skid

Overview:
- Parametrised N-input, WIDTH-bit select multiplexer with a registered output and a 2-entry skid buffer.
- Replaces the fixed 32-bit 2:1 datapath selectors where the selected operand must cross a pipeline-stage boundary under valid/ready flow control.
- Used between PPU operand-select and execute stages; supports stall (backpressure) and flush (squash on branch/exception).

Parameters:
- WIDTH, 32, data width of each input and the output.
- N, 2, number of inputs; legal range N >= 2.
- SELW, derived localparam = max(1, clog2(N)), select width; not overridable.

Ports:
- clk  input  1  rising-edge clock, the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  N*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SELW  input index, sampled on acceptance.
- in_valid  input  1  upstream offers a word.
- in_ready  output  1  block can accept a word.
- flush  input  1  synchronous squash of all buffered words.
- out_data  output  WIDTH  selected word at head of buffer.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream consumes the head word.
- sel_err  output  1  present only with MUX_SEL_ERR_EN (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY, out_valid 0, out_data 0, skid register 0, sel_err 0. No capture occurs while rst_n is low.
- Reset mid-operation discards both buffered words immediately, without waiting for a clock edge.
- Handshake events:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (state != FULL), decoded from the state register only; no combinational path from out_ready.
- Selected word = din[sel*WIDTH +: WIDTH] when sel < N, else all zeros.
- Latency: a word accepted in cycle t appears on out_data/out_valid in cycle t+1 if the buffer was EMPTY or popped in cycle t.
- States and transitions:
  - EMPTY: out_valid 0. accept -> ONE, head <= selected.
  - ONE: out_valid 1.
    - accept & pop -> ONE, head <= selected.
    - accept & !pop -> FULL, skid <= selected.
    - !accept & pop -> EMPTY.
    - otherwise hold.
  - FULL: in_ready 0. pop -> ONE, head <= skid. Otherwise hold; head and skid stay stable.
- Ordering is strictly FIFO; no word is duplicated or dropped except by flush.
- flush has priority over accept and pop in the same cycle: next state EMPTY, out_valid 0, head and skid cleared to 0, any concurrent input word dropped.
- out_data stays stable while out_valid=1 and out_ready=0.
- Throughput: one word per cycle with out_ready held high.

Optional Feature:
- Macro MUX_SEL_ERR_EN.
- Defined:
  - Each buffer entry carries a 1-bit error flag = (sel >= N) at acceptance.
  - sel_err presents the head entry's flag, qualified by out_valid.
  - The flag moves head/skid and is cleared by flush and reset exactly like data.
- Undefined:
  - sel_err port and flag storage absent.
  - Out-of-range select still yields zero data, with no indication.
- When N is a power of two sel >= N cannot occur, and sel_err ties to 0.

Decomposition:
- Package ppu_mux_pkg:
  - state encoding constants EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
  - clog2 constant function used to derive SELW.
- Sub-module mux_nx1_comb: purely combinational N-way WIDTH-bit selector with zero-on-out-of-range and an out-of-range flag output; instantiated once.
- The top level holds only state, head/skid registers and handshake logic.

Test Plan:
- Async reset: N=4, FULL with out_ready=0; drop rst_n between edges -> out_valid=0 and out_data=0 before the next clk edge; in_ready=1 after release.
- Streaming: N=4, din={0xDDDD0003,0xCCCC0002,0xBBBB0001,0xAAAA0000}, sel=0,1,2,3 on consecutive cycles, out_ready=1 -> out_data AAAA0000..DDDD0003 on cycles t+1..t+4; in_ready constant 1.
- Backpressure: out_ready=0, push sel=2 then sel=1 -> in_ready=0 after second accept, third in_valid held off; raise out_ready -> 0xCCCC0002 then 0xBBBB0001, in order, no duplication.
- Out-of-range: N=3, sel=2'd3 -> out_data=0; with MUX_SEL_ERR_EN, sel_err=1 on that word only and 0 on the following sel=0 word.
- Flush priority: FULL with in_valid=1, out_ready=1, flush=1 -> next cycle out_valid=0, in_ready=1; the offered word never appears at the output.
- Simultaneous accept+pop in ONE: head 0xAAAA0000 popped while sel=3 accepted -> next cycle state ONE, out_data=0xDDDD0003, skid unused.
